// File: rtl/adder_display_pkg.sv
// Shared types and constants for the operand-entry sequencer and its display scanner.
package adder_display_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_WAIT_B = 2'b01,
    S_SHOW   = 2'b10
  } state_t;

  localparam logic [1:0] AN_BLANK  = 2'b11;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/adder_display_ctrl_if.sv
// Board-side bundle: switches/buttons in, adder operands out, adder segments in, scanned display out.
interface adder_display_ctrl_if #(
  parameter int DW = 6
);
  logic [DW-1:0] sw;
  logic          btn_load;
  logic          btn_clear;
  logic [DW-1:0] sayi1;
  logic [DW-1:0] sayi2;
  logic [13:0]   seg_in;
  logic          dp_in;
  logic [6:0]    seg_out;
  logic          dp_out;
  logic [1:0]    an;
  logic [1:0]    state_o;

  modport slave (
    input  sw, btn_load, btn_clear, seg_in, dp_in,
    output sayi1, sayi2, seg_out, dp_out, an, state_o
  );

  modport master (
    output sw, btn_load, btn_clear, seg_in, dp_in,
    input  sayi1, sayi2, seg_out, dp_out, an, state_o
  );
endinterface

// File: rtl/adder_display_ctrl_seg_scan_mux.sv
// Two-digit 7-segment scanner: a SCAN_DIV-cycle slot counter toggles the active digit,
// and the registered segment/anode mux shows that digit (or blanks everything).
module seg_scan_mux
  import adder_display_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        blank,
  input  logic [13:0] seg_in,
  input  logic        dp_in,
  output logic [6:0]  seg_out,
  output logic        dp_out,
  output logic [1:0]  an
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] scan_cnt_q, scan_cnt_d;
  logic          digit_q, digit_d;
  logic          wrap;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [1:0]    an_q, an_d;

  always_comb begin
    wrap       = (scan_cnt_q == CW'(SCAN_DIV - 1));
    scan_cnt_d = wrap ? '0 : scan_cnt_q + 1'b1;
    digit_d    = digit_q ^ wrap;
  end

  // Anode gi is driven low only while its digit is the active one and the display is live.
  for (genvar gi = 0; gi < 2; gi++) begin : g_anode
    assign an_d[gi] = blank | (digit_q != 1'(gi));
  end

  always_comb begin
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (!blank) begin
      if (digit_q) begin
        seg_d = seg_in[13:7];
        dp_d  = ~dp_in;
      end else begin
        seg_d = seg_in[6:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q <= '0;
      digit_q    <= 1'b0;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
      an_q       <= AN_BLANK;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      digit_q    <= digit_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
    end
  end

  assign seg_out = seg_q;
  assign dp_out  = dp_q;
  assign an      = an_q;

endmodule

// File: rtl/adder_display_ctrl.sv
// Operand-entry sequencer: two LOAD presses capture A then B from the switches for the adder;
// the adder's two-digit result is scanned onto the shared 7-segment bus, blank while idle.
module adder_display_ctrl
  import adder_display_pkg::*;
#(
  parameter int DW       = 6,
  parameter int SCAN_DIV = 100000
) (
  input logic                clk,
  input logic                rst,
  adder_display_ctrl_if.slave bus
);

  state_t        state_q, state_d;
  logic [DW-1:0] op_a_q, op_a_d;
  logic [DW-1:0] op_b_q, op_b_d;
  logic          load_q, load_d;
  logic          load_rise;

  always_comb begin
    load_d    = bus.btn_load;
    load_rise = bus.btn_load & ~load_q;
  end

  // Clear has priority over a simultaneous load press.
  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    if (bus.btn_clear) begin
      state_d = S_IDLE;
      op_a_d  = '0;
      op_b_d  = '0;
    end else if (load_rise) begin
      case (state_q)
        S_WAIT_B: begin
          op_b_d  = bus.sw;
          state_d = S_SHOW;
        end
        default: begin
          op_a_d  = bus.sw;
          op_b_d  = '0;
          state_d = S_WAIT_B;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      load_q  <= load_d;
    end
  end

  assign bus.sayi1   = op_a_q;
  assign bus.sayi2   = op_b_q;
  assign bus.state_o = state_q;

  seg_scan_mux #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .blank   (state_q == S_IDLE),
    .seg_in  (bus.seg_in),
    .dp_in   (bus.dp_in),
    .seg_out (bus.seg_out),
    .dp_out  (bus.dp_out),
    .an      (bus.an)
  );

endmodule

// File: tb/tb_adder_display_ctrl.sv
// Bench for adder_display_ctrl: cycle-level behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized button/switch traffic.
module tb_adder_display_ctrl;

  localparam int DW       = 6;
  localparam int SCAN_DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adder_display_ctrl_if #(.DW(DW)) bus ();

  adder_display_ctrl #(
    .DW       (DW),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: state as 0/1/2, digit derived from cycles elapsed since reset.
  int         m_state = 0;
  int         m_a = 0, m_b = 0;
  int         m_k = 0;
  bit         m_prev_load = 0;
  bit         model_ok = 0;
  logic [1:0] e_an = 2'b11;
  logic [6:0] e_seg = 7'h7F;
  logic       e_dp = 1'b1;

  always @(posedge clk) begin
    if (rst) begin
      m_state = 0; m_a = 0; m_b = 0; m_k = 0; m_prev_load = 0;
      e_an = 2'b11; e_seg = 7'h7F; e_dp = 1'b1;
      model_ok = 1;
    end else begin
      if (m_state == 0) begin
        e_an = 2'b11; e_seg = 7'h7F; e_dp = 1'b1;
      end else if (((m_k / SCAN_DIV) % 2) == 0) begin
        e_an = 2'b10; e_seg = bus.seg_in[6:0]; e_dp = 1'b1;
      end else begin
        e_an = 2'b01; e_seg = bus.seg_in[13:7]; e_dp = ~bus.dp_in;
      end
      m_k++;
      if (bus.btn_clear) begin
        m_state = 0; m_a = 0; m_b = 0;
      end else if (bus.btn_load && !m_prev_load) begin
        if (m_state == 1) begin
          m_b = bus.sw; m_state = 2;
        end else begin
          m_a = bus.sw; m_b = 0; m_state = 1;
        end
      end
      m_prev_load = bus.btn_load;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("sayi1", 32'(bus.sayi1), 32'(m_a));
      chk("sayi2", 32'(bus.sayi2), 32'(m_b));
      chk("state_o", 32'(bus.state_o), 32'(m_state));
      chk("an", 32'(bus.an), 32'(e_an));
      chk("seg_out", 32'(bus.seg_out), 32'(e_seg));
      chk("dp_out", 32'(bus.dp_out), 32'(e_dp));
      chk("an_not_both_low", 32'(bus.an == 2'b00), 32'd0);
    end
  end

  // Adder-side segment/DP traffic changes every cycle so the mux is exercised throughout.
  initial begin
    bus.seg_in = 14'h0;
    bus.dp_in  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.seg_in = 14'($urandom);
      bus.dp_in  = 1'($urandom);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [DW-1:0] v);
    bus.sw = v;
    bus.btn_load = 1'b1;
    step(1);
    bus.btn_load = 1'b0;
    step(1);
  endtask

  initial begin
    bus.sw = '0;
    bus.btn_load = 1'b0;
    bus.btn_clear = 1'b0;
    rst = 1'b1;

    // 1: reset and idle blanking
    step(2);
    chk("rst_sayi1", 32'(bus.sayi1), 32'd0);
    chk("rst_sayi2", 32'(bus.sayi2), 32'd0);
    chk("rst_an", 32'(bus.an), 32'h3);
    chk("rst_seg", 32'(bus.seg_out), 32'h7F);
    chk("rst_state", 32'(bus.state_o), 32'd0);
    rst = 1'b0;
    step(5);
    chk("idle_an", 32'(bus.an), 32'h3);
    chk("idle_seg", 32'(bus.seg_out), 32'h7F);

    // 2: A=8, B=20
    press(6'd8);
    chk("t2_state_a", 32'(bus.state_o), 32'd1);
    chk("t2_sayi1", 32'(bus.sayi1), 32'd8);
    press(6'd20);
    chk("t2_state_b", 32'(bus.state_o), 32'd2);
    chk("t2_sayi2", 32'(bus.sayi2), 32'd20);
    step(12);

    // 3: new calculation from SHOW
    press(6'd25);
    chk("t3_wait", 32'(bus.state_o), 32'd1);
    chk("t3_b_zero", 32'(bus.sayi2), 32'd0);
    press(6'd18);
    chk("t3_sayi1", 32'(bus.sayi1), 32'd25);
    chk("t3_sayi2", 32'(bus.sayi2), 32'd18);
    chk("t3_state", 32'(bus.state_o), 32'd2);

    // 4: held load is a single event
    bus.sw = 6'b101100;
    bus.btn_load = 1'b1;
    step(10);
    chk("t4_sayi1", 32'(bus.sayi1), 32'h2C);
    chk("t4_state", 32'(bus.state_o), 32'd1);
    bus.btn_load = 1'b0;
    step(1);

    // 5: clear beats load in WAIT_B
    bus.sw = 6'd7;
    bus.btn_load = 1'b1;
    bus.btn_clear = 1'b1;
    step(1);
    bus.btn_load = 1'b0;
    bus.btn_clear = 1'b0;
    chk("t5_state", 32'(bus.state_o), 32'd0);
    chk("t5_sayi1", 32'(bus.sayi1), 32'd0);
    step(1);
    chk("t5_an", 32'(bus.an), 32'h3);

    // 6: reset mid-digit in SHOW
    press(6'd3);
    press(6'd5);
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("t6_state", 32'(bus.state_o), 32'd0);
    chk("t6_sayi2", 32'(bus.sayi2), 32'd0);
    chk("t6_an", 32'(bus.an), 32'h3);
    chk("t6_seg", 32'(bus.seg_out), 32'h7F);
    press(6'd1);
    press(6'd2);
    step(9);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      bus.sw = DW'($urandom);
      if ($urandom_range(0, 2) == 0) bus.btn_load = ~bus.btn_load;
      bus.btn_clear = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 149) == 0);
      step(1);
    end
    rst = 1'b0;
    bus.btn_clear = 1'b0;
    bus.btn_load = 1'b0;
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
